// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencer: Moore FSM driving datapath enables and selects.
// Memory phases wait on mem_ready so slow data memories can stall the FSM.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Funct,
  input  logic             zeroflag,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             IorD,
  output logic             IRWrite,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic [1:0]       PCSrc,
  output logic             pc_en,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC, ALUWB, ADDIEX, ADDIWB, BEQ, JMP, HALT
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  logic       fn_ok;
  logic [2:0] fn_alu;

  always_comb begin
    fn_ok  = 1'b1;
    fn_alu = 3'b000;
    unique case (Funct)
      6'b100000: fn_alu = 3'b010;
      6'b100010: fn_alu = 3'b110;
      6'b100100: fn_alu = 3'b000;
      6'b100101: fn_alu = 3'b001;
      6'b101010: fn_alu = 3'b111;
      default:   fn_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:  if (mem_ready) state_d = DECODE;
      DECODE: begin
        unique case (Opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXEC;
          OP_BEQ:       state_d = BEQ;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JMP;
          default:      state_d = HALT;
        endcase
      end
      MEMADR: state_d = (Opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  if (mem_ready) state_d = MEMWB;
      MEMWB:  state_d = FETCH;
      MEMWR:  if (mem_ready) state_d = FETCH;
      EXEC:   state_d = fn_ok ? ALUWB : HALT;
      ALUWB:  state_d = FETCH;
      ADDIEX: state_d = ADDIWB;
      ADDIWB: state_d = FETCH;
      BEQ:    state_d = FETCH;
      JMP:    state_d = FETCH;
      HALT:   state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == FETCH && state_q != FETCH)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  logic req_s, irw_s, mw_s, rw_s, pce_s;

  always_comb begin
    req_s      = 1'b0;
    irw_s      = 1'b0;
    mw_s       = 1'b0;
    rw_s       = 1'b0;
    pce_s      = 1'b0;
    IorD       = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    PCSrc      = 2'b00;
    halted     = 1'b0;
    unique case (state_q)
      FETCH: begin
        req_s      = 1'b1;
        irw_s      = mem_ready;
        pce_s      = mem_ready;
        ALUSrcB    = 2'b01;
        ALUControl = 3'b010;
      end
      DECODE: begin
        ALUSrcB    = 2'b11;
        ALUControl = 3'b010;
      end
      MEMADR, ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = 3'b010;
      end
      MEMRD: begin
        req_s = 1'b1;
        IorD  = 1'b1;
      end
      MEMWB: begin
        rw_s     = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        req_s = 1'b1;
        IorD  = 1'b1;
        mw_s  = mem_ready;
      end
      EXEC: begin
        ALUSrcA    = 1'b1;
        ALUControl = fn_alu;
      end
      ALUWB: begin
        rw_s   = 1'b1;
        RegDst = 1'b1;
      end
      ADDIWB: rw_s = 1'b1;
      BEQ: begin
        ALUSrcA    = 1'b1;
        ALUControl = 3'b110;
        PCSrc      = 2'b01;
        pce_s      = zeroflag;
      end
      JMP: begin
        PCSrc = 2'b10;
        pce_s = 1'b1;
      end
      HALT: halted = 1'b1;
      default: halted = 1'b1;
    endcase
  end

  // Reset masks every side-effecting strobe, whatever the state.
  assign mem_req     = req_s & reset;
  assign IRWrite     = irw_s & reset;
  assign MemWrite    = mw_s & reset;
  assign RegWrite    = rw_s & reset;
  assign pc_en       = pce_s & reset;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with a per-cycle scoreboard.
// Each step names the state the spec path implies and checks all outputs.
module tb_multicycle_control;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       Opcode, Funct;
  logic             zeroflag, mem_ready;
  logic             mem_req, IorD, IRWrite, MemWrite, RegWrite;
  logic             RegDst, MemtoReg, ALUSrcA, pc_en, halted;
  logic [1:0]       ALUSrcB, PCSrc;
  logic [2:0]       ALUControl;
  logic [CNT_W-1:0] instr_count;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct),
    .zeroflag(zeroflag), .mem_ready(mem_ready), .mem_req(mem_req),
    .IorD(IorD), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .PCSrc(PCSrc), .pc_en(pc_en), .halted(halted),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef enum int {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_ADDIEX, S_ADDIWB, S_BEQ, S_JMP, S_HALT
  } st_t;

  typedef struct {
    logic [16:0]      v;
    logic [CNT_W-1:0] c;
    string            tag;
  } exp_t;

  exp_t             sb[$];
  int               n_assert = 0;
  int               n_fail = 0;
  logic [CNT_W-1:0] cnt_exp = '0;
  st_t              prev_st = S_FETCH;
  bit               from_rst = 1'b1;

  function automatic logic [16:0] golden(st_t st);
    logic req, iord, irw, mw, rw, rd, m2r, sa, pce, hlt;
    logic [1:0] sb_, pcs;
    logic [2:0] alu;
    {req, iord, irw, mw, rw, rd, m2r, sa, pce, hlt} = '0;
    sb_ = 2'b00; pcs = 2'b00; alu = 3'b000;
    case (st)
      S_FETCH:  begin req = 1; irw = mem_ready; pce = mem_ready;
                      sb_ = 2'b01; alu = 3'b010; end
      S_DECODE: begin sb_ = 2'b11; alu = 3'b010; end
      S_MEMADR, S_ADDIEX: begin sa = 1; sb_ = 2'b10; alu = 3'b010; end
      S_MEMRD:  begin req = 1; iord = 1; end
      S_MEMWB:  begin rw = 1; m2r = 1; end
      S_MEMWR:  begin req = 1; iord = 1; mw = mem_ready; end
      S_EXEC: begin
        sa = 1;
        case (Funct)
          6'b100000: alu = 3'b010;
          6'b100010: alu = 3'b110;
          6'b100100: alu = 3'b000;
          6'b100101: alu = 3'b001;
          6'b101010: alu = 3'b111;
          default:   alu = 3'b000;
        endcase
      end
      S_ALUWB:  begin rw = 1; rd = 1; end
      S_ADDIWB: rw = 1;
      S_BEQ:    begin sa = 1; alu = 3'b110; pcs = 2'b01; pce = zeroflag; end
      S_JMP:    begin pcs = 2'b10; pce = 1; end
      S_HALT:   hlt = 1;
      default:  hlt = 1;
    endcase
    if (!reset) {req, irw, mw, rw, pce} = '0;
    return {req, iord, irw, mw, rw, rd, m2r, sa, sb_, alu, pcs, pce, hlt};
  endfunction

  function automatic logic [16:0] observed();
    return {mem_req, IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg,
            ALUSrcA, ALUSrcB, ALUControl, PCSrc, pc_en, halted};
  endfunction

  task automatic step(input st_t st, input string tag);
    exp_t e;
    if (st == S_FETCH && prev_st != S_FETCH && !from_rst)
      cnt_exp = cnt_exp + 1'b1;
    from_rst = 1'b0;
    e.v = golden(st); e.c = cnt_exp; e.tag = tag;
    sb.push_back(e);
    #2;
    e = sb.pop_front();
    n_assert++;
    assert (observed() === e.v) else begin
      n_fail++;
      $error("FAIL %s outputs: got %h want %h", e.tag, observed(), e.v);
    end
    n_assert++;
    assert (instr_count === e.c) else begin
      n_fail++;
      $error("FAIL %s count: got %0d want %0d", e.tag, instr_count, e.c);
    end
    if (!reset) begin cnt_exp = '0; from_rst = 1'b1; end
    prev_st = st;
    @(posedge clk); #1;
  endtask

  task automatic rst_step(input string tag);
    logic [4:0] en;
    #2;
    en = {pc_en, IRWrite, MemWrite, RegWrite, mem_req};
    n_assert++;
    assert (en === 5'b0) else begin
      n_fail++;
      $error("FAIL %s enables: got %b want 00000", tag, en);
    end
    cnt_exp = '0; from_rst = 1'b1; prev_st = S_FETCH;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0; mem_ready = 1'b1; zeroflag = 1'b0;
    Opcode = 6'b000000; Funct = 6'b100000;
    rst_step("rst0");
    rst_step("rst1");
    reset = 1'b1;

    Opcode = 6'b100011;
    step(S_FETCH, "lw_f"); step(S_DECODE, "lw_d"); step(S_MEMADR, "lw_a");
    step(S_MEMRD, "lw_r"); step(S_MEMWB, "lw_wb");
    Opcode = 6'b101011;
    step(S_FETCH, "sw_f"); step(S_DECODE, "sw_d"); step(S_MEMADR, "sw_a");
    step(S_MEMWR, "sw_w");
    Opcode = 6'b000000; Funct = 6'b100000;
    step(S_FETCH, "add_f"); step(S_DECODE, "add_d"); step(S_EXEC, "add_x");
    step(S_ALUWB, "add_wb");

    Opcode = 6'b000100; zeroflag = 1'b1;
    step(S_FETCH, "beq1_f"); step(S_DECODE, "beq1_d"); step(S_BEQ, "beq1_b");
    zeroflag = 1'b0;
    step(S_FETCH, "beq0_f"); step(S_DECODE, "beq0_d"); step(S_BEQ, "beq0_b");

    Opcode = 6'b100011;
    step(S_FETCH, "lws_f"); step(S_DECODE, "lws_d"); step(S_MEMADR, "lws_a");
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step(S_MEMRD, "lws_wait");
    mem_ready = 1'b1;
    step(S_MEMRD, "lws_r"); step(S_MEMWB, "lws_wb");

    Opcode = 6'b001000; Funct = 6'b100010;
    mem_ready = 1'b0;
    step(S_FETCH, "addi_stall"); step(S_FETCH, "addi_stall2");
    mem_ready = 1'b1;
    step(S_FETCH, "addi_f"); step(S_DECODE, "addi_d");
    step(S_ADDIEX, "addi_x"); step(S_ADDIWB, "addi_wb");
    Opcode = 6'b000010;
    step(S_FETCH, "j_f"); step(S_DECODE, "j_d"); step(S_JMP, "j_j");
    Opcode = 6'b000000; Funct = 6'b101010;
    step(S_FETCH, "slt_f"); step(S_DECODE, "slt_d"); step(S_EXEC, "slt_x");
    step(S_ALUWB, "slt_wb");

    Opcode = 6'b101011;
    step(S_FETCH, "swr_f"); step(S_DECODE, "swr_d"); step(S_MEMADR, "swr_a");
    mem_ready = 1'b0;
    step(S_MEMWR, "swr_wait");
    mem_ready = 1'b1; reset = 1'b0;
    step(S_MEMWR, "swr_rst");
    reset = 1'b1; Opcode = 6'b111111;
    step(S_FETCH, "ill_f"); step(S_DECODE, "ill_d");
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      zeroflag = ~i[0];
      step(S_HALT, "ill_halt");
    end
    reset = 1'b0; mem_ready = 1'b1;
    rst_step("rst_ill");
    reset = 1'b1; Opcode = 6'b000000; Funct = 6'b000000;
    step(S_FETCH, "badf_f"); step(S_DECODE, "badf_d"); step(S_EXEC, "badf_x");
    for (int i = 0; i < 10; i++) begin
      mem_ready = ~i[0];
      step(S_HALT, "badf_halt");
    end
    reset = 1'b0;
    rst_step("rst_end");
    reset = 1'b1; mem_ready = 1'b1;
    step(S_FETCH, "post_f");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
